times_table_axi_reader: RTL and testbench

TIMES_TABLE_AXI_READER -- requirements
Module: times_table_axi_reader

---
 rtl/times_table_axi_reader.sv | 116 +++++++++++
 tb/tb_times_table_axi_reader.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/times_table_axi_reader.sv
// Purpose : looks up a*b through one AXI4-Lite read at address {a,b}; result is the slave's rdata[5:0].
// Latency : start edge N -> AR handshake N+1 -> R handshake N+2 -> done high for the cycle after N+3 (zero-wait slave).
// Backpress: arvalid/araddr hold until arready; rready holds until rvalid; start is ignored (not queued) while busy.
//
// Ports: clk, rst (sync, active-low) | start, a, b request | busy, done, result, resp_err status |
//        arvalid/arready/araddr read-address channel | rvalid/rready/rdata/rresp read-data channel |
//        check_err (only with TIMES_TABLE_CHECK_EN defined: flags a slave answer that is not a*b).
// Optional feature macro: TIMES_TABLE_CHECK_EN.  DATA_W is expected to be wider than 6.
module times_table_axi_reader #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [2:0]        a,
    input  logic [2:0]        b,
    output logic              busy,
    output logic              done,
    output logic [5:0]        result,
    output logic              resp_err,
    output logic              arvalid,
    input  logic              arready,
    output logic [5:0]        araddr,
    input  logic              rvalid,
    output logic              rready,
    input  logic [DATA_W-1:0] rdata,
    input  logic [1:0]        rresp
`ifdef TIMES_TABLE_CHECK_EN
    ,
    output logic              check_err
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t     state_q;
    state_t     state_d;
    logic [2:0] a_q;
    logic [2:0] b_q;

    // Only the low six bits of the read data carry the product.
    logic unused_rdata_hi;
    assign unused_rdata_hi = ^rdata[DATA_W-1:6];

    assign araddr = {a_q, b_q};

    // Channel valids/readies come purely from state, never from the peer's handshake signal.
    always_comb begin
        state_d = state_q;
        arvalid = 1'b0;
        rready  = 1'b0;
        busy    = 1'b1;
        case (state_q)
            IDLE: begin
                busy = 1'b0;
                if (start) state_d = ADDR;
            end
            ADDR: begin
                arvalid = 1'b1;
                if (arready) state_d = DATA;
            end
            DATA: begin
                rready = 1'b1;
                if (rvalid) state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

`ifdef TIMES_TABLE_CHECK_EN
    logic [5:0] expect_prod;
    assign expect_prod = {3'b000, a_q} * {3'b000, b_q};
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= IDLE;
            a_q      <= 3'd0;
            b_q      <= 3'd0;
            result   <= 6'd0;
            resp_err <= 1'b0;
            done     <= 1'b0;
`ifdef TIMES_TABLE_CHECK_EN
            check_err <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            // The pulse is registered off the DONE state, so it appears in the cycle after DONE
            // and is exactly one cycle long.
            done    <= (state_q == DONE);
            if (state_q == IDLE && start) begin
                a_q <= a;
                b_q <= b;
            end
            // Capture happens only on the R handshake; rvalid in IDLE/ADDR never reaches here.
            if (state_q == DATA && rvalid) begin
                result   <= rdata[5:0];
                resp_err <= (rresp != 2'b00);
`ifdef TIMES_TABLE_CHECK_EN
                check_err <= (rdata[5:0] != expect_prod);
`endif
            end
        end
    end

endmodule

// File: tb/tb_times_table_axi_reader.sv
module tb_times_table_axi_reader;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  a = 3'd0;
    logic [2:0]  b = 3'd0;
    logic        busy;
    logic        done;
    logic [5:0]  result;
    logic        resp_err;
    logic        arvalid;
    logic        arready = 1'b0;
    logic [5:0]  araddr;
    logic        rvalid = 1'b0;
    logic        rready;
    logic [31:0] rdata = 32'd0;
    logic [1:0]  rresp = 2'd0;
`ifdef TIMES_TABLE_CHECK_EN
    logic        check_err;
    bit          exp_check = 1'b0;
`endif

    int checks = 0;
    int errors = 0;
    int cyc_n = 0;
    int done_seen = 0;
    int exp_done = 0;
    logic [5:0] exp_result = 6'd0;
    bit         exp_resp = 1'b0;

    times_table_axi_reader #(.DATA_W(32)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .a        (a),
        .b        (b),
        .busy     (busy),
        .done     (done),
        .result   (result),
        .resp_err (resp_err),
        .arvalid  (arvalid),
        .arready  (arready),
        .araddr   (araddr),
        .rvalid   (rvalid),
        .rready   (rready),
        .rdata    (rdata),
        .rresp    (rresp)
`ifdef TIMES_TABLE_CHECK_EN
        ,
        .check_err(check_err)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc_n++;
    always @(negedge clk) if (done) done_seen++;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // One lookup against an ideal slave with the given handshake delays and response.
    // hold keeps start high throughout (back-to-back), intrude pulses a 1*1 start while busy,
    // junk drives a stray rvalid during IDLE/ADDR that must be ignored.
    task automatic do_txn(input logic [2:0] ta, input logic [2:0] tb, input int ar_dly, input int r_dly,
                          input logic [31:0] rdat, input logic [1:0] rrsp,
                          input bit hold, input bit intrude, input bit junk);
        int t0;
        chk("held_result", 32'(result), 32'(exp_result));
        chk("held_resp_err", 32'(resp_err), 32'(exp_resp));
        a = ta; b = tb; start = 1'b1;
        if (junk) begin
            rvalid = 1'b1; rdata = $urandom; rresp = 2'($urandom_range(0, 3));
        end
        cyc();
        t0 = cyc_n;
        if (!hold) start = 1'b0;
        chk("busy_addr", 32'(busy), 1);
        chk("arvalid_addr", 32'(arvalid), 1);
        chk("rready_addr", 32'(rready), 0);
        chk("araddr", 32'(araddr), 32'({ta, tb}));
        for (int i = 0; i < ar_dly; i++) begin
            if (intrude && i == 0) begin start = 1'b1; a = 3'd1; b = 3'd1; end
            cyc();
            if (intrude && i == 0) start = hold;
            chk("arvalid_wait", 32'(arvalid), 1);
            chk("araddr_stable", 32'(araddr), 32'({ta, tb}));
        end
        rvalid = 1'b0; arready = 1'b1;
        cyc();
        arready = 1'b0;
        chk("arvalid_data", 32'(arvalid), 0);
        chk("rready_data", 32'(rready), 1);
        for (int i = 0; i < r_dly; i++) begin
            cyc();
            chk("rready_wait", 32'(rready), 1);
        end
        rvalid = 1'b1; rdata = rdat; rresp = rrsp;
        cyc();
        rvalid = 1'b0; rdata = $urandom;
        chk("done_early", 32'(done), 0);
        chk("rready_done", 32'(rready), 0);
        cyc();
        exp_result = rdat[5:0];
        exp_resp   = (rrsp != 2'b00);
        exp_done++;
        chk("done_pulse", 32'(done), 1);
        chk("latency", 32'(cyc_n - t0), 32'(ar_dly + r_dly + 3));
        chk("result", 32'(result), 32'(exp_result));
        chk("resp_err", 32'(resp_err), 32'(exp_resp));
        chk("busy_after", 32'(busy), 0);
        chk("arvalid_idle", 32'(arvalid), 0);
`ifdef TIMES_TABLE_CHECK_EN
        exp_check = (int'(rdat[5:0]) != int'(ta) * int'(tb));
        chk("check_err", 32'(check_err), 32'(exp_check));
`endif
        if (!hold) begin
            cyc();
            chk("done_single", 32'(done), 0);
            chk("busy_idle", 32'(busy), 0);
        end
    endtask

    initial begin
        logic [2:0]  ra, rb;
        logic [31:0] rd;
        // Reset state
        rst = 1'b0;
        cyc(); cyc();
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_arvalid", 32'(arvalid), 0);
        chk("rst_rready", 32'(rready), 0);
        chk("rst_result", 32'(result), 0);
        chk("rst_resp_err", 32'(resp_err), 0);
        chk("rst_araddr", 32'(araddr), 0);
        rst = 1'b1;
        cyc();

        // 7*7 zero-wait slave
        do_txn(3'd7, 3'd7, 0, 0, 32'd49, 2'b00, 1'b0, 1'b0, 1'b0);
        chk("res_49", 32'(result), 49);
        // 3*5 with arready held off five cycles
        do_txn(3'd3, 3'd5, 5, 0, 32'd15, 2'b00, 1'b0, 1'b0, 1'b0);
        chk("res_15", 32'(result), 15);
        // Error response then a clean one
        do_txn(3'd2, 3'd4, 0, 0, 32'd8, 2'b10, 1'b0, 1'b0, 1'b0);
        chk("err_set", 32'(resp_err), 1);
        do_txn(3'd2, 3'd4, 0, 1, 32'd8, 2'b00, 1'b0, 1'b0, 1'b0);
        chk("err_clear", 32'(resp_err), 0);
        // Start while busy is dropped; stray rvalid in IDLE/ADDR is dropped
        do_txn(3'd5, 3'd6, 2, 1, 32'd30, 2'b00, 1'b0, 1'b1, 1'b1);
        cyc(); cyc();
        chk("intrude_idle", 32'(busy), 0);
        chk("intrude_done_cnt", 32'(done_seen), 32'(exp_done));
        // Back-to-back with start held high
        do_txn(3'd4, 3'd3, 0, 0, 32'd12, 2'b00, 1'b1, 1'b0, 1'b0);
        do_txn(3'd1, 3'd6, 1, 0, 32'd6, 2'b00, 1'b1, 1'b0, 1'b0);
        start = 1'b0;
        cyc();
`ifdef TIMES_TABLE_CHECK_EN
        do_txn(3'd6, 3'd6, 0, 0, 32'd35, 2'b00, 1'b0, 1'b0, 1'b0);
        chk("check_35", 32'(check_err), 1);
        do_txn(3'd6, 3'd6, 0, 0, 32'd36, 2'b00, 1'b0, 1'b0, 1'b0);
        chk("check_36", 32'(check_err), 0);
`endif

        // Randomized lookups
        for (int n = 0; n < 40; n++) begin
            ra = 3'($urandom_range(0, 7));
            rb = 3'($urandom_range(0, 7));
            rd = ($urandom_range(0, 1) == 1) ? 32'(int'(ra) * int'(rb)) : $urandom;
            do_txn(ra, rb, $urandom_range(0, 3), $urandom_range(0, 3), rd,
                   ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00,
                   ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0), ($urandom_range(0, 2) == 0));
        end
        start = 1'b0;
        cyc(); cyc();

        // Reset while waiting for read data, then a late rvalid
        a = 3'd2; b = 3'd3; start = 1'b1;
        cyc();
        start = 1'b0; arready = 1'b1;
        cyc();
        arready = 1'b0;
        chk("pre_rst_rready", 32'(rready), 1);
        rst = 1'b0;
        cyc();
        rst = 1'b1;
        exp_result = 6'd0; exp_resp = 1'b0;
        rvalid = 1'b1; rdata = 32'd6; rresp = 2'b00;
        cyc();
        rvalid = 1'b0;
        cyc(); cyc();
        chk("rst_abandon_busy", 32'(busy), 0);
        chk("rst_abandon_result", 32'(result), 0);
        chk("rst_abandon_rready", 32'(rready), 0);
        chk("rst_abandon_araddr", 32'(araddr), 0);
        chk("done_count", 32'(done_seen), 32'(exp_done));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Bound on total run time in case the design stalls the sequence somewhere unexpected.
    initial begin
        #200000;
        $display("FAIL timeout: got %0d cycles expected completion", cyc_n);
        $fatal(1, "timeout");
    end

endmodule
